// File: rtl/uart_tx.sv
// UART transmitter: start, DBIT data bits LSB-first, optional parity (UART_TX_PARITY_EN), stop.
// Latency: tx falls on the accepting edge; tx_start is ignored while tx_busy, tx_done_tick pulses once per frame.
module uart_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tx_start,
  input  logic            s_tick,
  input  logic [DBIT-1:0] din,
`ifdef UART_TX_PARITY_EN
  input  logic            parity_odd,
`endif
  output logic            tx_busy,
  output logic            tx_done_tick,
  output logic            tx
);

  // Tick counter must also hold SB_TICK-1 for 1.5 / 2 stop bits.
  localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state_reg, state_next;
  logic [SW-1:0]   s_reg, s_next;
  logic [2:0]      n_reg, n_next;
  logic [DBIT-1:0] b_reg, b_next;
  logic            tx_reg, tx_next;
  logic            done_reg, done_next;
`ifdef UART_TX_PARITY_EN
  logic            par_reg, par_next;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      tx_reg    <= 1'b1;
      done_reg  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      tx_reg    <= tx_next;
      done_reg  <= done_next;
`ifdef UART_TX_PARITY_EN
      par_reg   <= par_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    done_next  = 1'b0;
    tx_next    = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_next   = par_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (tx_start) begin
          state_next = START;
          s_next     = '0;
          b_next     = din;
`ifdef UART_TX_PARITY_EN
          par_next   = ^din;
`endif
        end
      end
      START: begin
        if (s_tick) begin
          if (s_reg == SW'(15)) begin
            state_next = DATA;
            s_next     = '0;
            n_next     = '0;
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_reg == SW'(15)) begin
            s_next = '0;
            b_next = b_reg >> 1;
            if (n_reg == 3'(DBIT-1)) begin
`ifdef UART_TX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end else begin
              n_next = n_reg + 3'(1);
            end
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_reg == SW'(15)) begin
            state_next = STOP;
            s_next     = '0;
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (s_reg == SW'(SB_TICK-1)) begin
            state_next = IDLE;
            s_next     = '0;
            done_next  = 1'b1;
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level follows the next state so tx comes straight from a flop.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = b_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = par_next ^ parity_odd;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  assign tx_busy      = (state_reg != IDLE);
  assign tx_done_tick = done_reg;
  assign tx           = tx_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected frames, a line decoder pops and compares.
module tb_uart_tx;
  localparam int DBIT    = 8;
  localparam int SB_TICK = 16;
`ifdef UART_TX_PARITY_EN
  localparam int STOPI     = 10;
  localparam int FRAME_LEN = 176;
`else
  localparam int STOPI     = 9;
  localparam int FRAME_LEN = 160;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_start;
  logic       s_tick;
  logic [7:0] din;
`ifdef UART_TX_PARITY_EN
  logic       parity_odd;
`endif
  logic       tx_busy;
  logic       tx_done_tick;
  logic       tx;

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int done_cnt  = 0;
  int done_cyc  = 0;
  int start_cyc = 0;
  int tick_div  = 1;
  int tcnt      = 0;

  logic [8:0] sb_q[$];   // {expected parity bit, data byte}

  bit         in_frame = 1'b0;
  int         ck = 0;
  int         idx = 0;
  logic [7:0] sh = '0;
  logic       pbit = 1'b0;

  uart_tx #(.DBIT(DBIT), .SB_TICK(SB_TICK)) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_start     (tx_start),
    .s_tick       (s_tick),
    .din          (din),
`ifdef UART_TX_PARITY_EN
    .parity_odd   (parity_odd),
`endif
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick),
    .tx           (tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Tick source, equivalent to mod_m_counter with M = tick_div.
  initial begin
    s_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_div <= 1) s_tick = 1'b1;
      else begin
        tcnt   = (tcnt + 1) % tick_div;
        s_tick = (tcnt == 0);
      end
    end
  end

  // Line decoder: samples each bit mid-period by counting consumed ticks.
  always @(negedge clk) begin
    if (reset) begin
      in_frame = 1'b0;
    end else begin
      if (tx_done_tick) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (!in_frame && tx == 1'b0) begin
        in_frame  = 1'b1;
        ck        = 0;
        idx       = 0;
        sh        = '0;
        start_cyc = cyc;
      end
      if (in_frame) begin
        if (ck == 8 + 16 * idx) begin
          if (idx == 0) check("start_bit", {31'd0, tx}, 32'd0);
          else if (idx <= DBIT) sh[idx-1] = tx;
          else if (idx < STOPI) pbit = tx;
          else begin
            check("stop_bit", {31'd0, tx}, 32'd1);
            if (sb_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL sb_underflow: got frame %0h expected none", sh);
            end else begin
              logic [8:0] exp;
              exp = sb_q.pop_front();
              check("frame_data", {24'd0, sh}, {24'd0, exp[7:0]});
`ifdef UART_TX_PARITY_EN
              check("parity_bit", {31'd0, pbit}, {31'd0, exp[8]});
`endif
            end
            in_frame = 1'b0;
          end
          idx++;
        end
        if (s_tick) ck++;
      end
    end
  end

  task automatic step(int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(logic [7:0] d, logic p);
    din      = d;
    tx_start = 1'b1;
    sb_q.push_back({p, d});
    step(1);
    tx_start = 1'b0;
  endtask

  task automatic wait_idle(string name, int budget);
    int i = 0;
    while (tx_busy && i < budget) begin
      step(1);
      i++;
    end
    checks++;
    if (tx_busy) begin
      errors++;
      $display("FAIL %s_timeout: got busy after %0d cycles expected idle", name, budget);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int busy_low;
    int dur;
    bit seen;
    reset    = 1'b1;
    tx_start = 1'b0;
    din      = '0;
`ifdef UART_TX_PARITY_EN
    parity_odd = 1'b0;
`endif
    step(3);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_done", {31'd0, tx_done_tick}, 32'd0);
    reset = 1'b0;
    step(2);

    // Tick every clock, A5: expect 1,0,1,0,0,1,0,1 on the line LSB first.
    d0 = done_cnt;
    send(8'hA5, 1'b0);
    wait_idle("a5", 400);
    step(2);
    check("a5_len", done_cyc - start_cyc, FRAME_LEN);
    check("a5_done_cnt", done_cnt - d0, 1);

    // Start request with FF during an all-zero frame must be ignored.
    d0 = done_cnt;
    send(8'h00, 1'b0);
    step(40);
    din      = 8'hFF;
    tx_start = 1'b1;
    step(1);
    tx_start = 1'b0;
    wait_idle("ign", 400);
    step(2);
    check("ign_done_cnt", done_cnt - d0, 1);

    // Back-to-back: tx_start held high, second byte taken in the done cycle.
    d0       = done_cnt;
    din      = 8'h55;
    tx_start = 1'b1;
    sb_q.push_back({1'b0, 8'h55});
    step(1);
    din = 8'hAA;
    sb_q.push_back({1'b0, 8'hAA});
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      step(1);
      if (tx_done_tick) seen = 1'b1;
    end
    check("b2b_first_done", {31'd0, seen}, 32'd1);
    step(1);
    tx_start = 1'b0;
    check("b2b_restart_busy", {31'd0, tx_busy}, 32'd1);
    step(1);
    check("b2b_gap", start_cyc - done_cyc, 1);
    wait_idle("b2b", 400);
    step(2);
    check("b2b_done_cnt", done_cnt - d0, 2);

    // Divided tick (M=16): every bit lasts 256 clocks.
    tick_div = 16;
    tcnt     = 0;
    d0       = done_cnt;
    busy_low = 0;
    seen     = 1'b0;
    send(8'h3C, 1'b0);
    for (int i = 0; i < 3200 && !seen; i++) begin
      step(1);
      if (tx_done_tick) seen = 1'b1;
      else if (!tx_busy) busy_low++;
    end
    check("div_done_seen", {31'd0, seen}, 32'd1);
    check("div_busy_gaps", busy_low, 0);
    step(2);
    dur = done_cyc - start_cyc;
    check("div_len_in_range", {31'd0, (dur > FRAME_LEN*16 - 16) && (dur <= FRAME_LEN*16)}, 32'd1);
    check("div_done_cnt", done_cnt - d0, 1);
    tick_div = 1;
    step(20);

    // Reset in the middle of data bit 3: line high and idle at once, no done.
    din      = 8'h96;
    tx_start = 1'b1;
    step(1);
    tx_start = 1'b0;
    step(71);
    check("mid_busy_before", {31'd0, tx_busy}, 32'd1);
    d0    = done_cnt;
    reset = 1'b1;
    #1;
    check("mid_rst_tx", {31'd0, tx}, 32'd1);
    check("mid_rst_busy", {31'd0, tx_busy}, 32'd0);
    step(2);
    reset = 1'b0;
    step(250);
    check("mid_rst_no_done", done_cnt - d0, 0);
    check("mid_rst_idle_tx", {31'd0, tx}, 32'd1);

`ifdef UART_TX_PARITY_EN
    // 07 has three ones: even parity bit 1, odd parity bit 0.
    parity_odd = 1'b0;
    send(8'h07, 1'b1);
    wait_idle("par_even", 400);
    step(2);
    check("par_even_len", done_cyc - start_cyc, 176);
    parity_odd = 1'b1;
    send(8'h07, 1'b0);
    wait_idle("par_odd", 400);
    step(2);
    check("par_odd_len", done_cyc - start_cyc, 176);
`endif

    check("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
